// File: rtl/uart_tx.sv
// Bus-mapped UART transmitter: TXDATA/STATUS registers, transmit buffer, 8N1 serialiser.
// Define UART_TX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx #(
   parameter int unsigned DIVISOR = 868,
   parameter int unsigned DEPTH   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        bus_sel,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_data_w,
   input  logic [3:0]  bus_mask_w,
   output logic [31:0] bus_data_r,
   output logic        tx
);

   localparam int unsigned BaudW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [BaudW-1:0] BaudLoad = BaudW'(DIVISOR - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [BaudW-1:0] baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            ovf_q;

   logic       push_req, push, pop, full, empty, busy, ovf_clr, baud_done;
   logic [7:0] head;
   logic [2:0] bit_nx;

   assign push_req  = bus_sel & ~bus_addr[0] & bus_mask_w[0];
   assign ovf_clr   = bus_sel & bus_addr[0] & (|bus_mask_w);
   assign busy      = (state_q != StIdle);
   assign baud_done = (baud_q == '0);
   assign pop       = ~empty & ((state_q == StIdle) | ((state_q == StStop) & baud_done));
   // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
   assign push      = push_req & (~full | pop);
   assign bit_nx    = bit_q + 3'd1;

   logic unused_bits;
   assign unused_bits = ^{bus_addr[29:1], bus_data_w[31:8]};

`ifdef UART_TX_FIFO_EN
   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [PtrW:0]   cnt_q;

   assign full  = (cnt_q == (PtrW + 1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_q];

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= bus_data_w[7:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end
`else
   logic       hold_valid_q;
   logic [7:0] hold_q;
   logic [31:0] unused_depth;

   assign unused_depth = DEPTH;
   assign full  = hold_valid_q;
   assign empty = ~hold_valid_q;
   assign head  = hold_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else if (push) begin
         hold_valid_q <= 1'b1;
         hold_q       <= bus_data_w[7:0];
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end else if (push_req && full && !pop) begin
         ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_data_r <= '0;
      end else if (bus_sel && !(|bus_mask_w) && bus_addr[0]) begin
         bus_data_r <= {28'b0, ovf_q, busy, empty, full};
      end else begin
         bus_data_r <= '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!empty) begin
                  state_q <= StStart;
                  shift_q <= head;
                  baud_q  <= BaudLoad;
                  tx      <= 1'b0;
               end
            end
            StStart: begin
               if (baud_done) begin
                  state_q <= StData;
                  baud_q  <= BaudLoad;
                  bit_q   <= '0;
                  tx      <= shift_q[0];
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            StData: begin
               if (baud_done) begin
                  baud_q <= BaudLoad;
                  if (bit_q == 3'd7) begin
                     state_q <= StStop;
                     tx      <= 1'b1;
                  end else begin
                     bit_q <= bit_nx;
                     tx    <= shift_q[bit_nx];
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            StStop: begin
               if (baud_done) begin
                  // Back-to-back frames: reload straight into START with no idle gap.
                  if (!empty) begin
                     state_q <= StStart;
                     shift_q <= head;
                     baud_q  <= BaudLoad;
                     tx      <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with DIVISOR=4, DEPTH=4; a line monitor
// records every frame (40 samples) and its start cycle for comparison against hand values.
module tb_uart_tx;

   localparam int unsigned Div = 4;
   localparam int unsigned Depth = 4;
`ifdef UART_TX_FIFO_EN
   localparam int Dep = Depth;
`else
   localparam int Dep = 1;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        bus_sel = 1'b0;
   logic [29:0] bus_addr = '0;
   logic [31:0] bus_data_w = '0;
   logic [3:0]  bus_mask_w = '0;
   logic [31:0] bus_data_r;
   logic        tx;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [39:0] frames_q [$];
   int          starts_q [$];

   uart_tx #(.DIVISOR(Div), .DEPTH(Depth)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus_sel    (bus_sel),
      .bus_addr   (bus_addr),
      .bus_data_w (bus_data_w),
      .bus_mask_w (bus_mask_w),
      .bus_data_r (bus_data_r),
      .tx         (tx)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Line monitor: a low sample outside a frame starts a 40-sample capture.
   initial begin
      logic [39:0] bits;
      int          st;
      forever begin
         @(posedge clock); #2;
         if (tx === 1'b0) begin
            st = cyc;
            bits = '0;
            for (int i = 1; i < 40; i++) begin
               @(posedge clock); #2;
               bits[i] = tx;
            end
            frames_q.push_back(bits);
            starts_q.push_back(st);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] frame_bits(input logic [7:0] b);
      logic [39:0] r;
      for (int i = 0; i < 40; i++) begin
         int k;
         k = i / 4;
         r[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      end
      return r;
   endfunction

   task automatic bus_write(input logic [29:0] addr, input logic [7:0] data,
                            input logic [3:0] mask);
      bus_sel = 1'b1; bus_addr = addr; bus_data_w = {24'hABCDEF, data}; bus_mask_w = mask;
      @(posedge clock); #1;
      bus_sel = 1'b0; bus_mask_w = '0;
   endtask

   task automatic bus_read(input logic sel, input logic [29:0] addr, output logic [31:0] data);
      bus_sel = sel; bus_addr = addr; bus_mask_w = '0;
      @(posedge clock); #1;
      data = bus_data_r;
      bus_sel = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic flush();
      frames_q.delete();
      starts_q.delete();
   endtask

   task automatic check_frames(input string tag, input int n, input logic [7:0] first);
      check({tag, "_count"}, frames_q.size(), n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_frame%0d", tag, i),
               (i < frames_q.size()) ? frames_q[i] : 40'h0, frame_bits(first + 8'(i)));
      end
   endtask

   initial begin
      logic [31:0] rd;
      int p;

      repeat (3) @(posedge clock);
      #1;
      check("reset_tx", tx, 1);
      check("reset_data_r", bus_data_r, 0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Register access timing.
      bus_sel = 1'b1; bus_addr = 30'h1; bus_mask_w = '0;
      #3;
      check("status_before_edge", bus_data_r, 0);
      @(posedge clock); #1;
      check("status_idle", bus_data_r, 32'h2);
      bus_read(1'b0, 30'h1, rd);
      check("read_unselected", rd, 0);
      bus_read(1'b1, 30'h3FFF_FFFD, rd);
      check("status_upper_addr", rd, 32'h2);
      bus_read(1'b1, 30'h0, rd);
      check("txdata_read", rd, 0);
      bus_read(1'b1, 30'h1, rd);
      bus_write(30'h1, 8'h00, 4'hF);
      check("write_clears_data_r", bus_data_r, 0);
      bus_write(30'h0, 8'h77, 4'b0010);
      repeat (10) @(posedge clock);
      #1;
      check("mask0_ignored_frames", frames_q.size(), 0);
      bus_read(1'b1, 30'h1, rd);
      check("mask0_ignored_status", rd, 32'h2);

      // Single frame 0x55 and busy release timing.
      flush();
      bus_write(30'h0, 8'h55, 4'h1);
      p = cyc;
      repeat (40) @(posedge clock);
      #1;
      bus_read(1'b1, 30'h1, rd);
      check("busy_last_stop_cycle", rd, 32'h6);
      bus_read(1'b1, 30'h1, rd);
      check("busy_cleared", rd, 32'h2);
      repeat (5) @(posedge clock);
      #1;
      check_frames("f55", 1, 8'h55);
      check("f55_start_latency", (starts_q.size() > 0) ? starts_q[0] - p : -1, 1);

      // Back-to-back frames.
      flush();
      bus_write(30'h0, 8'hA5, 4'h1);
      bus_write(30'h0, 8'h3C, 4'h1);
      repeat (90) @(posedge clock);
      #1;
      check("b2b_count", frames_q.size(), 2);
      check("b2b_frame0", (frames_q.size() > 0) ? frames_q[0] : 40'h0, frame_bits(8'hA5));
      check("b2b_frame1", (frames_q.size() > 1) ? frames_q[1] : 40'h0, frame_bits(8'h3C));
      check("b2b_gap", (starts_q.size() > 1) ? starts_q[1] - starts_q[0] : -1, 40);
      bus_read(1'b1, 30'h1, rd);
      check("b2b_status", rd, 32'h2);

      // Overflow: Dep+2 pushes, one dropped.
      flush();
      for (int i = 0; i < Dep + 2; i++) bus_write(30'h0, 8'h10 + 8'(i), 4'h1);
      bus_read(1'b1, 30'h1, rd);
      check("ovf_status", rd, 32'hD);
      bus_write(30'h1, 8'h00, 4'h1);
      bus_read(1'b1, 30'h1, rd);
      check("ovf_cleared", rd, 32'h5);
      repeat ((Dep + 1) * 40 + 60) @(posedge clock);
      #1;
      check_frames("ovf", Dep + 1, 8'h10);
      bus_read(1'b1, 30'h1, rd);
      check("ovf_drained_status", rd, 32'h2);

      // Push into a full buffer on the STOP->START pop cycle.
      flush();
      bus_write(30'h0, 8'h20, 4'h1);
      p = cyc;
      for (int i = 1; i < Dep + 1; i++) bus_write(30'h0, 8'h20 + 8'(i), 4'h1);
      wait_until(p + 40);
      bus_write(30'h0, 8'h20 + 8'(Dep + 1), 4'h1);
      bus_read(1'b1, 30'h1, rd);
      check("edge_push_status", rd, 32'h5);
      repeat ((Dep + 2) * 40 + 20) @(posedge clock);
      #1;
      check_frames("edge", Dep + 2, 8'h20);

      // Reset mid-frame aborts and discards.
      flush();
      bus_write(30'h0, 8'h00, 4'h1);
      p = cyc;
      bus_write(30'h0, 8'h00, 4'h1);
      wait_until(p + 14);
      bus_sel = 1'b1; bus_addr = 30'h1; bus_mask_w = '0;
      @(posedge clock); #1;
`ifdef UART_TX_FIFO_EN
      check("pre_reset_status", bus_data_r, 32'h4);
`else
      check("pre_reset_status", bus_data_r, 32'h5);
`endif
      check("pre_reset_tx", tx, 0);
      #2 reset = 1'b0;
      #1;
      check("reset_async_tx", tx, 1);
      check("reset_async_data_r", bus_data_r, 0);
      bus_sel = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      repeat (50) @(posedge clock);
      #1;
      flush();
      repeat (60) @(posedge clock);
      #1;
      check("post_reset_no_frames", frames_q.size(), 0);
      bus_read(1'b1, 30'h1, rd);
      check("post_reset_status", rd, 32'h2);

      // First push after reset release.
      flush();
      bus_write(30'h0, 8'hC3, 4'h1);
      p = cyc;
      repeat (50) @(posedge clock);
      #1;
      check_frames("after_reset", 1, 8'hC3);
      check("after_reset_latency", (starts_q.size() > 0) ? starts_q[0] - p : -1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
